uart_cmd_resp: RTL and testbench
================================

// Module: uart_cmd_resp
// PURPOSE
//  DUT-side end of the host command link: responder to the host command master.
//  Receives 16-bit commands over UART as two bytes, high byte first, and presents them to the LA command processor.
//  Serializes 8-bit responses (0xA5 ack, 0xEE nak, dump data) back to the host.
//  Sits between the RX/TX pins and the command-config block inside LA_dig, on the 100MHz system clk.
// PARAMETERS
//  BAUD_DIV        109      clk cycles per UART bit (100MHz / 921600 baud, rounded)
//  TIMEOUT_CYCLES  2000000  max clk cycles allowed between high and low byte (CMD_TIMEOUT_EN only)
// PORTS
//  clk          in   1   100MHz system clock
//  rst_n        in   1   asynchronous active-low reset
//  RX           in   1   serial in from host (asynchronous, idles high)
//  TX           out  1   serial out to host (idles high)
//  cmd          out  16  last complete command, {high_byte, low_byte}
//  cmd_rdy      out  1   complete command available in cmd
//  clr_cmd_rdy  in   1   knocks down cmd_rdy
//  send_resp    in   1   one-cycle strobe: transmit resp
//  resp         in   8   response byte, sampled on the send_resp cycle
//  resp_sent    out  1   response fully transmitted (level)
// BEHAVIOUR
//  Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0. The RX synchronizer presets to 1. The assembler resets to HIGH.
//  RX path:
//   - 2-flop synchronizer on RX.
//   - A falling edge while idle starts reception.
//   - First sample at BAUD_DIV/2 checks the start bit. Start bit high at that sample = glitch; return to idle.
//   - Data bits are sampled every BAUD_DIV cycles after that, LSB first, 8 data bits, then the stop bit.
//   - Stop bit = 0: framing error; the byte is discarded and the assembler state is unchanged.
//  Byte assembler FSM:
//   - States HIGH, LOW.
//   - HIGH: a good byte is stored as the high byte; go to LOW.
//   - LOW: a good byte sets cmd={hi,lo} and cmd_rdy=1 on the same clk; go to HIGH.
//   - cmd_rdy clears on clr_cmd_rdy, or at the start bit of the next high byte.
//   - If the set and clear conditions occur in the same cycle, set wins.
//   - cmd is held stable while cmd_rdy=1, except when a newer complete command overwrites it. No overrun flag.
//  TX path:
//   - States IDLE, XMIT.
//   - send_resp in IDLE loads {1'b1, resp, 1'b0} and clears resp_sent. TX drops to the start bit on the next clk.
//   - 10 bits at BAUD_DIV cycles each.
//   - After the stop bit: return to IDLE and set resp_sent=1, which holds until the next send_resp.
//   - send_resp during XMIT is ignored; the byte in flight is not corrupted.
//   - resp_sent rises 10*BAUD_DIV+1 clks after send_resp.
//  RX and TX are fully independent (full duplex): transmitting never stalls reception.
//  Reset mid-byte or mid-command: everything returns to reset values immediately and any partial byte or high byte is discarded.
//  Counters: the baud counter is 7 bits wide and the bit counter 4 bits wide; neither wraps past the terminal value.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined:
//   - A counter runs while the assembler is in LOW.
//   - When it reaches TIMEOUT_CYCLES with no low byte, the assembler returns to HIGH and the stale high byte is dropped.
//   - The next byte is then taken as a new high byte.
//   - The counter restarts on every entry to LOW.
//  CMD_TIMEOUT_EN undefined:
//   - No timeout logic is built.
//   - LOW waits indefinitely; only reset resynchronizes the assembler.
// TESTING
//  1. Host sends 0x08,0x13 -> cmd=16'h0813 and cmd_rdy=1 within 1 clk of the second stop-bit sample.
//     Then pulse clr_cmd_rdy -> cmd_rdy=0 and cmd still 16'h0813.
//  2. send_resp with resp=8'hA5 -> TX sequence 0,1,0,1,0,0,1,0,1,1, each bit BAUD_DIV clks.
//     resp_sent=1 at 10*BAUD_DIV+1 clks; the host master receives 0xA5.
//  3. send_resp again 5 clks after the first, with resp=8'h00 -> ignored; the host still receives only 0xA5.
//  4. Byte 0x02 sent with stop bit forced low, then 0x02,0x55 -> cmd=16'h0255.
//     The bad byte leaves no trace, and cmd_rdy pulses exactly once.
//  5. rst_n asserted mid low byte of 0x0A0B -> TX=1, cmd_rdy=0, cmd=0.
//     Then 0x0C,0x0D after reset -> cmd=16'h0C0D.
//  6. With CMD_TIMEOUT_EN defined and TIMEOUT_CYCLES=5000: send 0x11, wait 6000 clks, send 0x22,0x33 -> cmd=16'h2233.
//     Without the macro, the same stimulus gives cmd=16'h1122.

Source files
------------

// File: rtl/uart_cmd_resp_if.sv
// Host command link bundle: serial pins plus the command/response handshake
// between this responder and the LA command processor.
interface uart_cmd_resp_if;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    modport slave (
        input  RX, clr_cmd_rdy, send_resp, resp,
        output TX, cmd, cmd_rdy, resp_sent
    );

    modport master (
        output RX, clr_cmd_rdy, send_resp, resp,
        input  TX, cmd, cmd_rdy, resp_sent
    );
endinterface

// File: rtl/uart_cmd_resp.sv
// UART command responder: two-byte command assembly (high byte first) and 8-bit
// response serializer. Optional high/low byte timeout is built only with CMD_TIMEOUT_EN.
module uart_cmd_resp #(
    parameter int BAUD_DIV       = 109,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_cmd_resp_if.slave bus
);
    localparam logic [6:0] BAUD_LAST = 7'(BAUD_DIV - 1);
    localparam logic [6:0] HALF_LAST = 7'(BAUD_DIV / 2 - 1);

    if (BAUD_DIV < 4 || BAUD_DIV > 128 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("uart_cmd_resp: BAUD_DIV must be 4..128 and TIMEOUT_CYCLES >= 2");
    end

    // ------------------------------------------------------------------
    // RX synchronizer and falling-edge detect (all preset to line idle)
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    // ------------------------------------------------------------------
    // RX byte FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t  rx_state_q, rx_state_d;
    logic [6:0] rx_baud_q, rx_baud_d;
    logic [3:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_start_ok;
    logic       rx_byte_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_baud_d  = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit check: a line already back high was only a glitch
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 7'd1;
                end
            end
            RX_DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 7'd1;
                end
            end
            RX_STOP: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_baud_d = rx_baud_q + 7'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_start_ok = (rx_state_q == RX_START) && (rx_baud_q == HALF_LAST) && !rx_sync_q;
        rx_byte_ok  = (rx_state_q == RX_STOP)  && (rx_baud_q == BAUD_LAST) &&  rx_sync_q;
    end

    // ------------------------------------------------------------------
    // Byte assembler FSM
    // ------------------------------------------------------------------
    typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;

    asm_state_t  asm_state_q, asm_state_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        asm_timeout;

`ifdef CMD_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // Held at zero outside LOW so every entry to LOW starts a fresh window
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (asm_state_q != ASM_LOW) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign asm_timeout = (asm_state_q == ASM_LOW) && (to_cnt_q == TO_LAST);
`else
    assign asm_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state_q <= ASM_HIGH;
            hi_byte_q   <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
        end else begin
            asm_state_q <= asm_state_d;
            hi_byte_q   <= hi_byte_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
        end
    end

    always_comb begin
        asm_state_d = asm_state_q;
        case (asm_state_q)
            ASM_HIGH: if (rx_byte_ok) asm_state_d = ASM_LOW;
            ASM_LOW:  if (rx_byte_ok || asm_timeout) asm_state_d = ASM_HIGH;
            default:  asm_state_d = ASM_HIGH;
        endcase
    end

    always_comb begin
        hi_byte_d = hi_byte_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (bus.clr_cmd_rdy || (rx_start_ok && asm_state_q == ASM_HIGH)) begin
            cmd_rdy_d = 1'b0;
        end
        // Set is evaluated last so it wins over a same-cycle clear
        if (rx_byte_ok) begin
            if (asm_state_q == ASM_HIGH) begin
                hi_byte_d = rx_shift_q;
            end else begin
                cmd_d     = {hi_byte_q, rx_shift_q};
                cmd_rdy_d = 1'b1;
            end
        end
    end

    assign bus.cmd     = cmd_q;
    assign bus.cmd_rdy = cmd_rdy_q;

    // ------------------------------------------------------------------
    // TX response FSM
    // ------------------------------------------------------------------
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    tx_state_t  tx_state_q, tx_state_d;
    logic [9:0] tx_shift_q, tx_shift_d;
    logic [6:0] tx_baud_q, tx_baud_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic       resp_sent_q, resp_sent_d;
    logic       tx_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '1;
            tx_baud_q   <= '0;
            tx_bit_q    <= '0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign tx_last = (tx_baud_q == BAUD_LAST) && (tx_bit_q == 4'd9);

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (bus.send_resp) tx_state_d = TX_XMIT;
            TX_XMIT: if (tx_last) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Shift register fills with ones so TX comes straight off a flop and idles high
    always_comb begin
        tx_shift_d  = tx_shift_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        resp_sent_d = resp_sent_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_shift_d  = {1'b1, bus.resp, 1'b0};
                    tx_baud_d   = '0;
                    tx_bit_d    = '0;
                    resp_sent_d = 1'b0;
                end
            end
            TX_XMIT: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    if (tx_bit_q == 4'd9) begin
                        resp_sent_d = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 7'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.TX        = tx_shift_q[0];
    assign bus.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Directed bench for uart_cmd_resp: table of host bytes with expected command
// state, plus hand sequences for response TX, glitch, reset and timeout.
module tb_uart_cmd_resp;
    localparam int BD = 109;
    localparam int TO = 5000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_resp_if bus();

    uart_cmd_resp #(.BAUD_DIV(BD), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int rdy_rises = 0;
    logic rdy_prev = 1'b0;

    always @(posedge clk) begin
        rdy_prev <= bus.cmd_rdy;
        if (bus.cmd_rdy && !rdy_prev) rdy_rises <= rdy_rises + 1;
    end

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        clr;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
    } rx_vec_t;

    rx_vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.RX = 1'b0;
        wait_clks(BD);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            wait_clks(BD);
        end
        bus.RX = stop;
        wait_clks(BD);
        bus.RX = 1'b1;
        wait_clks(BD);
    endtask

    task automatic tx_check(input logic [7:0] r, input bit poke, input logic [9:0] exp_frame);
        logic [9:0] got;
        int lat;
        int lows;
        got = '0;
        lat = -1;
        lows = 0;
        bus.resp = r;
        bus.send_resp = 1'b1;
        for (int k = 1; k <= 10 * BD + 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus.send_resp = 1'b0;
                chk("tx_start_next_clk", {31'd0, bus.TX}, 32'd0);
                chk("resp_sent_cleared", {31'd0, bus.resp_sent}, 32'd0);
            end
            if (poke && k == 5) begin
                bus.resp = 8'h00;
                bus.send_resp = 1'b1;
            end
            if (poke && k == 6) bus.send_resp = 1'b0;
            for (int i = 0; i < 10; i++)
                if (k == i * BD + BD / 2 + 1) got[i] = bus.TX;
            if (lat < 0 && bus.resp_sent) lat = k;
        end
        chk("tx_frame", {22'd0, got}, {22'd0, exp_frame});
        chk("resp_sent_latency", lat, 10 * BD + 1);
        for (int k = 0; k < 2 * BD; k++) begin
            @(posedge clk);
            #1;
            if (!bus.TX) lows++;
        end
        chk("tx_idle_after", lows, 0);
        chk("resp_sent_held", {31'd0, bus.resp_sent}, 32'd1);
    endtask

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h08, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{8'h13, 1'b1, 1'b1, 16'h0813, 1'b1};
        vecs[2] = '{8'h02, 1'b0, 1'b0, 16'h0813, 1'b0};
        vecs[3] = '{8'h02, 1'b1, 1'b0, 16'h0813, 1'b0};
        vecs[4] = '{8'h55, 1'b1, 1'b0, 16'h0255, 1'b1};
        vecs[5] = '{8'hAB, 1'b1, 1'b0, 16'h0255, 1'b0};
        vecs[6] = '{8'hCD, 1'b1, 1'b0, 16'hABCD, 1'b1};
        vecs[7] = '{8'h12, 1'b1, 1'b0, 16'hABCD, 1'b0};
        vecs[8] = '{8'h34, 1'b1, 1'b1, 16'h1234, 1'b1};

        bus.RX = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b0;
        bus.resp = 8'h00;

        #2 rst_n = 1'b0;
        wait_clks(3);
        chk("reset_TX", {31'd0, bus.TX}, 32'd1);
        chk("reset_cmd", {16'd0, bus.cmd}, 32'd0);
        chk("reset_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("reset_resp_sent", {31'd0, bus.resp_sent}, 32'd0);
        rst_n = 1'b1;
        wait_clks(5);

        for (int v = 0; v < 9; v++) begin
            send_byte(vecs[v].data, vecs[v].stop);
            chk($sformatf("v%0d_cmd", v), {16'd0, bus.cmd}, {16'd0, vecs[v].exp_cmd});
            chk($sformatf("v%0d_cmd_rdy", v), {31'd0, bus.cmd_rdy}, {31'd0, vecs[v].exp_rdy});
            if (vecs[v].clr) begin
                bus.clr_cmd_rdy = 1'b1;
                wait_clks(1);
                bus.clr_cmd_rdy = 1'b0;
                wait_clks(1);
                chk($sformatf("v%0d_clr_rdy", v), {31'd0, bus.cmd_rdy}, 32'd0);
                chk($sformatf("v%0d_clr_cmd", v), {16'd0, bus.cmd}, {16'd0, vecs[v].exp_cmd});
            end
        end
        chk("cmd_rdy_rise_count", rdy_rises, 4);

        // Short low glitch must not start a byte or disturb the assembler
        bus.RX = 1'b0;
        wait_clks(10);
        bus.RX = 1'b1;
        wait_clks(2 * BD);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        chk("glitch_then_cmd", {16'd0, bus.cmd}, 32'h5AA5);
        chk("glitch_then_rdy", {31'd0, bus.cmd_rdy}, 32'd1);

        tx_check(8'hA5, 1'b1, 10'h34A);
        tx_check(8'h3C, 1'b0, 10'h278);

        // Reset in the middle of the low byte of 0x0A0B while a response is in flight
        send_byte(8'h0A, 1'b1);
        bus.resp = 8'h81;
        bus.send_resp = 1'b1;
        bus.RX = 1'b0;
        wait_clks(1);
        bus.send_resp = 1'b0;
        wait_clks(BD - 1);
        bus.RX = 1'b1;
        wait_clks(BD);
        bus.RX = 1'b1;
        wait_clks(BD);
        bus.RX = 1'b0;
        wait_clks(BD + BD / 2);
        chk("pre_reset_TX_busy", {31'd0, bus.TX}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midreset_TX", {31'd0, bus.TX}, 32'd1);
        chk("midreset_cmd", {16'd0, bus.cmd}, 32'd0);
        chk("midreset_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        bus.RX = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(5);
        send_byte(8'h0C, 1'b1);
        send_byte(8'h0D, 1'b1);
        chk("post_reset_cmd", {16'd0, bus.cmd}, 32'h0C0D);
        chk("post_reset_rdy", {31'd0, bus.cmd_rdy}, 32'd1);

        // Stale high byte followed by a long gap
        send_byte(8'h11, 1'b1);
        wait_clks(6000);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
`ifdef CMD_TIMEOUT_EN
        chk("timeout_cmd", {16'd0, bus.cmd}, 32'h2233);
        chk("timeout_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
`else
        chk("no_timeout_cmd", {16'd0, bus.cmd}, 32'h1122);
        chk("no_timeout_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
